soc_run_monitor: RTL
====================

Name: soc_run_monitor

Overview:
Synthesizable run controller and completion checker, directly downstream of zeroriscy_soc.
- Drives the SoC's fetch_enable_i.
- Consumes the SoC's mem_flag, mem_result and instr_addr.
- Detects program completion, compares the result against an expected value, and flags timeout or PC-hang.
- Replaces the ad-hoc $finish/timeout logic in benches and allows on-chip/FPGA self-test.

Parameters:
TIMEOUT_CYCLES, 1000, max RUN cycles before TIMEOUT (>=1)
HANG_CYCLES, 64, consecutive cycles with unchanged instr_addr before HANG; 0 disables hang detection
CNT_W, 32, width of cycle counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse, starts a run (accepted only in IDLE)
clear_i  in  1  returns terminal state to IDLE
expected_i  in  32  expected mem_result value, sampled on start accept
mem_flag_i  in  32  SoC completion flag; nonzero = done
mem_result_i  in  32  SoC result word
instr_addr_i  in  32  SoC current fetch address
fetch_enable_o  out  1  to SoC fetch_enable_i
busy_o  out  1  high in RUN
done_o  out  1  high in any terminal state
pass_o  out  1  high only in PASS
status_o  out  3  encoded state (pkg enum)
result_o  out  32  captured mem_result
cycles_o  out  CNT_W  cycles spent in RUN, frozen at terminal

Behaviour:
Reset:
- Reset is asynchronous on rst_ni low. Everything is zero; state IDLE.
- Reset mid-run aborts immediately; fetch_enable_o drops in the same delta as the reset.

States: IDLE, RUN, PASS, FAIL, TIMEOUT, HANG.
- IDLE:
  - All outputs low.
  - On start_i: go to RUN next edge. Latch expected_i. Clear cycles and the stall counter. Load last_addr with instr_addr_i.
- RUN:
  - fetch_enable_o=1, busy_o=1.
  - cycles increments by 1 each cycle in RUN; the first RUN cycle shows 1 on the following edge.
  - Checks evaluated every RUN cycle, in priority order:
    1. mem_flag_i!=0: capture mem_result_i into result_o. Go to PASS if it equals the latched expected, else FAIL. The cycles increment for this cycle is included.
    2. cycles+1 == TIMEOUT_CYCLES: go to TIMEOUT.
    3. HANG_CYCLES!=0 and stall+1 == HANG_CYCLES with instr_addr_i == last_addr: go to HANG.
  - Stall counter:
    - instr_addr_i != last_addr: stall<=0, last_addr<=instr_addr_i.
    - Else stall<=stall+1, saturating at HANG_CYCLES.
- Terminal states (PASS/FAIL/TIMEOUT/HANG):
  - fetch_enable_o=0, done_o=1.
  - result_o and cycles_o held.
  - clear_i: go to IDLE next edge and zero result_o and cycles_o.
  - start_i is ignored.
- start_i and clear_i together in IDLE: start wins. clear_i in IDLE or RUN is ignored.
- cycles saturates at all-ones; it cannot exceed TIMEOUT_CYCLES when CNT_W is sufficient.
- mem_flag_i high at the moment of start acceptance (still in IDLE) is ignored. Only mem_flag_i during RUN counts.
- All outputs are registered. Latency from the mem_flag_i edge to done_o is 1 cycle.

Decomposition:
- Package soc_run_pkg:
  - typedef enum logic[2:0] run_state_e: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4, HANG=5.
  - Default localparams for the parameters above.
- Sub-module soc_pc_stall_det: holds last_addr and the stall counter, outputs hang_o. Parameter HANG_CYCLES; inputs clk_i, rst_ni, en_i, clr_i, instr_addr_i.

Test Plan:
1. start, expected=0x37. instr_addr increments every cycle. At RUN cycle 20, mem_flag=1 and mem_result=0x37 -> next edge: PASS, pass_o=1, result_o=0x37, cycles_o=20, fetch_enable_o=0.
2. Same as 1 but mem_result=0x36 -> FAIL, pass_o=0, done_o=1, result_o=0x36.
3. TIMEOUT_CYCLES=50, mem_flag held 0, addr toggling -> TIMEOUT with cycles_o=50. Then clear_i -> IDLE with all outputs 0.
4. HANG_CYCLES=8. At cycle 10, instr_addr frozen at 0x80 -> HANG at RUN cycle 18. Addr changing every 7 cycles -> no HANG.
5. Cycle where mem_flag is set and the timeout count is reached together -> PASS/FAIL, not TIMEOUT. mem_flag and hang condition together -> PASS/FAIL.
6. rst_ni low asynchronously mid-RUN at cycle 5 -> fetch_enable_o=0 immediately, state IDLE. After release, a new start runs with cycles counting from 1.

Source files
------------

// File: rtl/soc_run_pkg.sv
// Shared types and default parameter values for the SoC run monitor.
package soc_run_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4,
    HANG    = 3'd5
  } run_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 1000;
  localparam int DEF_HANG_CYCLES    = 64;
  localparam int DEF_CNT_W          = 32;

  function automatic logic is_terminal(input run_state_e s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT) || (s == HANG);
  endfunction

endpackage

// File: rtl/soc_pc_stall_det.sv
// Tracks the last fetch address and how many consecutive run cycles it has
// stayed unchanged; hang_o flags the cycle on which the stall limit is reached.
module soc_pc_stall_det
  import soc_run_pkg::*;
#(
  parameter int HANG_CYCLES = DEF_HANG_CYCLES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] instr_addr_i,
  output logic        hang_o
);

  localparam int SW = (HANG_CYCLES < 2) ? 1 : $clog2(HANG_CYCLES + 1);
  localparam logic [SW:0]   HANG_LIM  = (SW + 1)'(HANG_CYCLES);
  localparam logic [SW-1:0] STALL_MAX = SW'(HANG_CYCLES);

  logic [31:0]   last_addr_q, last_addr_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [SW:0]   stall_inc;
  logic          same_addr;

  always_comb begin
    same_addr   = (instr_addr_i == last_addr_q);
    stall_inc   = {1'b0, stall_q} + (SW + 1)'(1);
    last_addr_d = last_addr_q;
    stall_d     = stall_q;
    if (clr_i) begin
      last_addr_d = instr_addr_i;
      stall_d     = '0;
    end else if (en_i) begin
      if (!same_addr) begin
        last_addr_d = instr_addr_i;
        stall_d     = '0;
      end else if (stall_q != STALL_MAX) begin
        stall_d = stall_inc[SW-1:0];
      end
    end
    // Fires on the cycle whose increment would reach the limit, so the
    // controller can leave RUN on that same edge.
    hang_o = (HANG_CYCLES != 0) && en_i && same_addr && (stall_inc == HANG_LIM);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_addr_q <= '0;
      stall_q     <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: rtl/soc_run_monitor.sv
// Run controller for the SoC: enables fetch, watches for completion, and
// classifies the run as pass, fail, timeout or PC hang.
module soc_run_monitor
  import soc_run_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HANG_CYCLES    = DEF_HANG_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [31:0]      expected_i,
  input  logic [31:0]      mem_flag_i,
  input  logic [31:0]      mem_result_i,
  input  logic [31:0]      instr_addr_i,
  output logic             fetch_enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [2:0]       status_o,
  output logic [31:0]      result_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  run_state_e       state_q, state_d;
  logic [31:0]      expected_q, expected_d;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cycles_inc;
  logic             fetch_en_q, fetch_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             start_acc;
  logic             in_run;
  logic             hang;

  assign start_acc = (state_q == IDLE) && start_i;
  assign in_run    = (state_q == RUN);

  soc_pc_stall_det #(
    .HANG_CYCLES (HANG_CYCLES)
  ) u_stall_det (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (in_run),
    .clr_i        (start_acc),
    .instr_addr_i (instr_addr_i),
    .hang_o       (hang)
  );

  always_comb begin
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
    state_d    = state_q;
    expected_d = expected_q;
    result_d   = result_q;
    cycles_d   = cycles_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = RUN;
          expected_d = expected_i;
          result_d   = '0;
          cycles_d   = '0;
        end
      end
      RUN: begin
        cycles_d = cycles_inc;
        // Completion outranks timeout, which outranks hang.
        if (mem_flag_i != '0) begin
          result_d = mem_result_i;
          state_d  = (mem_result_i == expected_q) ? PASS : FAIL;
        end else if (cycles_inc == TIMEOUT_LIM) begin
          state_d = TIMEOUT;
        end else if (hang) begin
          state_d = HANG;
        end
      end
      PASS, FAIL, TIMEOUT, HANG: begin
        if (clear_i) begin
          state_d  = IDLE;
          result_d = '0;
          cycles_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flag outputs are decoded from the next state so they register in step with it.
    fetch_en_d = (state_d == RUN);
    busy_d     = (state_d == RUN);
    done_d     = is_terminal(state_d);
    pass_d     = (state_d == PASS);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      expected_q <= '0;
      result_q   <= '0;
      cycles_q   <= '0;
      fetch_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      result_q   <= result_d;
      cycles_q   <= cycles_d;
      fetch_en_q <= fetch_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign fetch_enable_o = fetch_en_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign status_o       = state_q;
  assign result_o       = result_q;
  assign cycles_o       = cycles_q;

endmodule
